// File: rtl/uart_pkg.sv
// Shared types and sizes for the 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned FRAME_BITS_8N1 = 10;
  localparam int unsigned BIT_IDX_W      = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick_o is high on the last clk cycle of each bit period.
// clr_i holds the count at zero so a new frame starts on a period boundary.
module uart_baud_tick #(
  parameter int unsigned CLOCKS_PER_BAUD = 33
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_BAUD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // tick is registered from the next count so it coincides with cnt_q == LAST
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx_8n1.sv
// Byte-wide 8N1 serial transmitter, LSB first, one frame per accepted start_i.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and stop.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BAUD = 33
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 start_i,
  output logic                 done_o,
  output logic                 tx
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  uart_tx_state_t         state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [BIT_IDX_W-1:0]   bit_idx_q;
  logic                   tx_q;
  logic                   done_q;
  logic                   baud_clr_c;
  logic                   tick;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  // Timer is held cleared while idle so the start bit gets a full period
  assign baud_clr_c = (state_q == IDLE);

  uart_baud_tick #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_baud (
    .clk   (clk),
    .rst_ni(rst_ni),
    .clr_i (baud_clr_c),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i && done_q) begin
            shift_q   <= data_i;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            done_q    <= 1'b0;
            state_q   <= START;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^data_i;
`endif
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx     = tx_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Scoreboard bench for uart_tx_8n1: stimulus queues expected frames, a monitor
// samples tx mid-bit and measures how long done_o stays low for each frame.
module tb_uart_tx_8n1;

  localparam int CPB = 33;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [10:0] F54 = 11'h6A8;
  localparam logic [10:0] FA5 = 11'h54A;
  localparam logic [10:0] F00 = 11'h400;
  localparam logic [10:0] FFF = 11'h5FE;
`else
  localparam int NBITS = 10;
  localparam logic [10:0] F54 = 11'h2A8;
  localparam logic [10:0] FA5 = 11'h34A;
  localparam logic [10:0] F00 = 11'h200;
  localparam logic [10:0] FFF = 11'h3FE;
`endif

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       start_i = 1'b0;
  logic       done_o;
  logic       tx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] bits;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_8n1 #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .data_i (data_i),
    .start_i(start_i),
    .done_o (done_o),
    .tx     (tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (!done_o && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check({name, "_idle"}, 32'(done_o), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [10:0] bits, input string name);
    exp_q.push_back('{bits: bits, name: name});
    @(negedge clk);
    data_i  = d;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Monitor: frame begins when done_o falls; tx sampled at the middle of each bit
  initial begin : monitor
    logic prev_done;
    exp_t e;
    bit   have;
    bit   aborted;
    int   lowcnt;
    int   guard;
    int   wait_n;
    prev_done = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_ni && prev_done && !done_o) begin
        have = (exp_q.size() != 0);
        if (have) begin
          e = exp_q.pop_front();
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got frame start at %0t expected none", $time);
        end
        lowcnt  = 1;
        aborted = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
          wait_n = (b == 0) ? CPB / 2 : CPB;
          for (int k = 0; k < wait_n && !aborted; k++) begin
            @(negedge clk);
            if (!rst_ni) aborted = 1'b1;
            else if (!done_o) lowcnt++;
          end
          if (aborted) break;
          if (have) check($sformatf("%s_bit%0d", e.name, b), 32'(tx), 32'(e.bits[b]));
        end
        guard = 0;
        while (!aborted && !done_o && guard < 2 * NBITS * CPB) begin
          @(negedge clk);
          if (!rst_ni) aborted = 1'b1;
          else if (!done_o) lowcnt++;
          guard++;
        end
        if (!aborted && have) check({e.name, "_frame_len"}, 32'(lowcnt), 32'(NBITS * CPB));
      end
      prev_done = done_o;
    end
  end

  initial begin : stimulus
    int g;
    int hi;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_done", 32'(done_o), 32'd1);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_done", 32'(done_o), 32'd1);

    // Basic frame
    send(8'h54, F54, "f54");
    check("accept_done_low", 32'(done_o), 32'd0);
    check("accept_tx_low", 32'(tx), 32'd0);
    wait_idle("f54");

    // data_i change after acceptance
    repeat (3) @(negedge clk);
    send(8'h54, F54, "f54_datachg");
    data_i = 8'hFF;
    wait_idle("f54_datachg");

    // start_i mid-frame must be ignored
    repeat (3) @(negedge clk);
    send(8'h54, F54, "f54_ignore");
    repeat (100) @(negedge clk);
    data_i  = 8'h0F;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle("f54_ignore");
    repeat (40) @(negedge clk);
    check("ignore_still_idle", 32'(done_o), 32'd1);

    // start_i held high: two contiguous frames
    repeat (3) @(negedge clk);
    exp_q.push_back('{bits: FA5, name: "fa5_a"});
    exp_q.push_back('{bits: FA5, name: "fa5_b"});
    @(negedge clk);
    data_i  = 8'hA5;
    start_i = 1'b1;
    g = 0;
    while (done_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    g = 0;
    while (!done_o && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("b2b_stop_tx", 32'(tx), 32'd1);
    hi = 0;
    while (done_o && hi < 5) begin
      hi++;
      @(negedge clk);
    end
    start_i = 1'b0;
    check("b2b_done_high_cycles", 32'(hi), 32'd1);
    check("b2b_start_tx", 32'(tx), 32'd0);
    wait_idle("fa5_b");

    // Boundary data patterns
    repeat (3) @(negedge clk);
    send(8'h00, F00, "f00");
    wait_idle("f00");
    repeat (3) @(negedge clk);
    send(8'hFF, FFF, "fff");
    wait_idle("fff");

    // Reset mid-frame (data bit 3 of 8'h54 is 0)
    repeat (3) @(negedge clk);
    send(8'h54, F54, "f54_rst");
    repeat (140) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_done", 32'(done_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h54, F54, "f54_after_rst");
    wait_idle("f54_after_rst");

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion by %0t expected finish", $time);
    $fatal(1);
  end

endmodule
